wb_scoreboard: RTL and testbench

WB_SCOREBOARD -- requirements
Module: wb_scoreboard

---
 rtl/wb_scoreboard_pkg.sv | 12 +
 rtl/wb_scoreboard_if.sv | 33 +++
 rtl/wb_scoreboard_cnt.sv | 38 +++
 rtl/wb_scoreboard.sv | 94 +++++++++
 tb/tb_wb_scoreboard.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_scoreboard_pkg.sv
// Shared ISA definitions for the writeback scoreboard: register-number
// constants and the default limit on outstanding register writes.
package wb_scoreboard_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_RA   = 5'd31;

    localparam int MAX_INFLIGHT_DEFAULT = 4;

endpackage

// File: rtl/wb_scoreboard_if.sv
// Decode/retire bus between the pipeline and the scoreboard.
// The pipeline side is the master; the scoreboard is the slave.
interface wb_scoreboard_if;
    import wb_scoreboard_pkg::*;

    logic        issue_valid;
    reg_idx_t    issue_dest;
    reg_idx_t    issue_rs;
    reg_idx_t    issue_rt;
    logic        use_rs;
    logic        use_rt;
    logic        wb_valid;
    reg_idx_t    wb_reg;
    logic        flush;
    logic        stall;
    logic        issue_fire;
    logic [31:0] busy;
    logic [2:0]  inflight;
    logic        underflow_err;

    modport master (
        output issue_valid, issue_dest, issue_rs, issue_rt, use_rs, use_rt,
        output wb_valid, wb_reg, flush,
        input  stall, issue_fire, busy, inflight, underflow_err
    );

    modport slave (
        input  issue_valid, issue_dest, issue_rs, issue_rt, use_rs, use_rt,
        input  wb_valid, wb_reg, flush,
        output stall, issue_fire, busy, inflight, underflow_err
    );

endinterface

// File: rtl/wb_scoreboard_cnt.sv
// Two-bit saturating pending-write counter for one architectural register.
// Simultaneous inc and dec leave the count unchanged; clr wins over both.
module wb_scoreboard_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       clr_i,
    output logic [1:0] cnt_o
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 2'd0;
        end else if (inc_i && !dec_i && (cnt_q != 2'd3)) begin
            cnt_d = cnt_q + 2'd1;
        end else if (dec_i && !inc_i && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_scoreboard.sv
// Register writeback scoreboard: tracks outstanding writes per register and
// stalls decode on RAW hazards, counter saturation or the in-flight limit.
module wb_scoreboard
    import wb_scoreboard_pkg::*;
#(
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    wb_scoreboard_if.slave     bus
);

    logic [1:0]  cnt_s [32];
    logic        stall_s;
    logic        fire_s;
    logic        issue_inc_s;
    logic        wb_dec_s;
    logic        wb_under_s;
    logic [31:0] busy_s;
    logic [2:0]  inflight_q;
    logic [2:0]  inflight_d;
    logic        underflow_q;

    assign cnt_s[0] = 2'd0;

    for (genvar n = 1; n <= int'(REG_RA); n++) begin : g_cnt
        wb_scoreboard_cnt u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc_i (issue_inc_s && (bus.issue_dest == 5'(n))),
            .dec_i (wb_dec_s && (bus.wb_reg == 5'(n))),
            .clr_i (bus.flush),
            .cnt_o (cnt_s[n])
        );
    end

    // Hazard check sees only registered state, so a retire clears a hazard one cycle later.
    always_comb begin
        stall_s = 1'b0;
        if (bus.issue_valid) begin
            stall_s = (bus.use_rs && (bus.issue_rs != REG_ZERO) && (cnt_s[bus.issue_rs] != 2'd0))
                   || (bus.use_rt && (bus.issue_rt != REG_ZERO) && (cnt_s[bus.issue_rt] != 2'd0))
                   || ((bus.issue_dest != REG_ZERO) && (cnt_s[bus.issue_dest] == 2'd3))
                   || ((bus.issue_dest != REG_ZERO) && (inflight_q == 3'(MAX_INFLIGHT)));
        end else begin
            stall_s = 1'b0;
        end
    end

    assign fire_s      = bus.issue_valid && !stall_s;
    assign issue_inc_s = fire_s && (bus.issue_dest != REG_ZERO) && !bus.flush;
    assign wb_dec_s    = bus.wb_valid && (bus.wb_reg != REG_ZERO)
                      && (cnt_s[bus.wb_reg] != 2'd0) && !bus.flush;
    assign wb_under_s  = bus.wb_valid && (bus.wb_reg != REG_ZERO)
                      && (cnt_s[bus.wb_reg] == 2'd0) && !bus.flush;

    // Total counter moves in lockstep with the per-register counters.
    always_comb begin
        inflight_d = inflight_q;
        if (bus.flush) begin
            inflight_d = 3'd0;
        end else if (issue_inc_s && !wb_dec_s) begin
            inflight_d = inflight_q + 3'd1;
        end else if (wb_dec_s && !issue_inc_s) begin
            inflight_d = inflight_q - 3'd1;
        end else begin
            inflight_d = inflight_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q  <= 3'd0;
            underflow_q <= 1'b0;
        end else begin
            inflight_q  <= inflight_d;
            underflow_q <= underflow_q | wb_under_s;
        end
    end

    always_comb begin
        busy_s = 32'd0;
        for (int n = 1; n < 32; n++) begin
            busy_s[n] = (cnt_s[n] != 2'd0);
        end
    end

    assign bus.stall         = stall_s;
    assign bus.issue_fire    = fire_s;
    assign bus.busy          = busy_s;
    assign bus.inflight      = inflight_q;
    assign bus.underflow_err = underflow_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed scoreboard bench: expectations are queued as stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_wb_scoreboard;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];

    wb_scoreboard_if bus ();

    wb_scoreboard #(.MAX_INFLIGHT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return {31'd0, bus.stall};
            1:       return {31'd0, bus.issue_fire};
            2:       return bus.busy;
            3:       return {29'd0, bus.inflight};
            4:       return {31'd0, bus.underflow_err};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check_pending();
        exp_t        e;
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic idle_inputs();
        bus.issue_valid = 1'b0;
        bus.issue_dest  = 5'd0;
        bus.issue_rs    = 5'd0;
        bus.issue_rt    = 5'd0;
        bus.use_rs      = 1'b0;
        bus.use_rt      = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_reg      = 5'd0;
        bus.flush       = 1'b0;
    endtask

    // One cycle of stimulus; stall/fire are checked at the falling edge.
    task automatic cyc(input string tag, input logic iv, input logic [4:0] d,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic wv,
                       input logic [4:0] wr, input logic fl, input logic exp_stall);
        bus.issue_valid = iv;
        bus.issue_dest  = d;
        bus.issue_rs    = rs;
        bus.issue_rt    = rt;
        bus.use_rs      = urs;
        bus.use_rt      = urt;
        bus.wb_valid    = wv;
        bus.wb_reg      = wr;
        bus.flush       = fl;
        exp_q.push_back('{tag: {tag, ".stall"}, sel: 0, exp: {31'd0, exp_stall}});
        exp_q.push_back('{tag: {tag, ".fire"},  sel: 1, exp: {31'd0, iv & ~exp_stall}});
        @(negedge clk);
        check_pending();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic iss(input string tag, input logic [4:0] d, input logic exp_stall);
        cyc(tag, 1'b1, d, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, exp_stall);
    endtask

    task automatic ret(input string tag, input logic [4:0] wr);
        cyc(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, wr, 1'b0, 1'b0);
    endtask

    task automatic st(input string tag, input logic [31:0] b, input logic [2:0] inf, input logic uf);
        exp_q.push_back('{tag: {tag, ".busy"},     sel: 2, exp: b});
        exp_q.push_back('{tag: {tag, ".inflight"}, sel: 3, exp: {29'd0, inf}});
        exp_q.push_back('{tag: {tag, ".uf"},       sel: 4, exp: {31'd0, uf}});
        check_pending();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        st("reset", 32'h0, 3'd0, 1'b0);
        cyc("idle", 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        iss("dest0", 5'd0, 1'b0);
        st("dest0", 32'h0, 3'd0, 1'b0);

        // RAW on r5, cleared one cycle after its retire
        iss("i5", 5'd5, 1'b0);
        st("i5", 32'h20, 3'd1, 1'b0);
        cyc("raw5a", 1'b1, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        cyc("raw5b", 1'b1, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        cyc("raw5ret", 1'b1, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
        st("raw5ret", 32'h0, 3'd0, 1'b0);
        cyc("raw5go", 1'b1, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        st("raw5go", 32'h40, 3'd1, 1'b0);
        cyc("rawrt", 1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        cyc("nouse", 1'b1, 5'd0, 5'd6, 5'd6, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        ret("r6", 5'd6);
        st("r6", 32'h0, 3'd0, 1'b0);

        // Per-register saturation at three outstanding writes
        iss("i7a", 5'd7, 1'b0);
        iss("i7b", 5'd7, 1'b0);
        iss("i7c", 5'd7, 1'b0);
        st("i7x3", 32'h80, 3'd3, 1'b0);
        iss("i7d", 5'd7, 1'b1);
        cyc("i7ret", 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1);
        st("i7ret", 32'h80, 3'd2, 1'b0);
        iss("i7e", 5'd7, 1'b0);
        st("i7e", 32'h80, 3'd3, 1'b0);
        ret("r7a", 5'd7);
        ret("r7b", 5'd7);
        ret("r7c", 5'd7);
        st("r7x3", 32'h0, 3'd0, 1'b0);

        // In-flight limit of four
        iss("i1", 5'd1, 1'b0);
        iss("i2", 5'd2, 1'b0);
        iss("i3", 5'd3, 1'b0);
        iss("i4", 5'd4, 1'b0);
        st("full", 32'h1E, 3'd4, 1'b0);
        iss("i6full", 5'd6, 1'b1);
        cyc("d0ok", 1'b1, 5'd0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        st("d0ok", 32'h1E, 3'd4, 1'b0);
        cyc("fullret", 1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1);
        st("fullret", 32'h1C, 3'd3, 1'b0);
        iss("i6", 5'd6, 1'b0);
        st("i6", 32'h5C, 3'd4, 1'b0);
        ret("r2", 5'd2);
        ret("r3", 5'd3);
        ret("r4", 5'd4);
        ret("r6b", 5'd6);
        st("drain", 32'h0, 3'd0, 1'b0);

        // Same-cycle issue/retire, same and different registers
        iss("i9", 5'd9, 1'b0);
        st("i9", 32'h200, 3'd1, 1'b0);
        cyc("same9", 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        st("same9", 32'h200, 3'd1, 1'b0);
        ret("r9", 5'd9);
        st("r9", 32'h0, 3'd0, 1'b0);
        iss("i3b", 5'd3, 1'b0);
        cyc("diff38", 1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
        st("diff38", 32'h100, 3'd1, 1'b0);
        ret("r8", 5'd8);
        ret("r0", 5'd0);
        st("r0", 32'h0, 3'd0, 1'b0);

        // Underflow is sticky through flush, cleared only by reset
        ret("r12", 5'd12);
        st("uf12", 32'h0, 3'd0, 1'b1);
        iss("f4", 5'd4, 1'b0);
        iss("f5", 5'd5, 1'b0);
        iss("f6", 5'd6, 1'b0);
        st("preflush", 32'h70, 3'd3, 1'b1);
        cyc("flush", 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        st("flush", 32'h0, 3'd0, 1'b1);
        iss("i10", 5'd10, 1'b0);
        iss("i11", 5'd11, 1'b0);
        st("prereset", 32'hC00, 3'd2, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        st("midreset", 32'h0, 3'd0, 1'b0);
        iss("postreset", 5'd10, 1'b0);
        st("postreset", 32'h400, 3'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
